temporizador_bcd: RTL and testbench
===================================

// Module: temporizador_bcd
// PURPOSE
//  BCD countdown timer, HH:MM:SS. Produces the timer digits HORAT/MINT/SEGT and the ALARMA flag
//  consumed by the VGA display stage. Sits directly upstream of that stage.
//  Load, start, pause and acknowledge come from the user/RTC control logic.
//  Counts down once per second, derived from CLK by an internal prescaler.
// PARAMETERS
//  TICK_DIV    100_000_000  CLK cycles per 1 s tick (bench uses 4)
//  ALARM_SECS  10           ticks ALARMA stays high before auto-clear
// PORTS
//  CLK      in   1  system clock; all logic on rising edge
//  RST      in   1  synchronous reset, active-low (0 = reset)
//  LOAD     in   1  one-cycle pulse: load HORA_IN/MIN_IN/SEG_IN
//  HORA_IN  in   8  BCD hours 00-23
//  MIN_IN   in   8  BCD minutes 00-59
//  SEG_IN   in   8  BCD seconds 00-59
//  START    in   1  one-cycle pulse: begin/resume countdown
//  STOP     in   1  one-cycle pulse: pause countdown
//  ACK      in   1  one-cycle pulse: clear alarm
//  HORAT    out  8  BCD hours remaining   [7:4] tens, [3:0] units
//  MINT     out  8  BCD minutes remaining
//  SEGT     out  8  BCD seconds remaining
//  ALARMA   out  1  high while in ALARM state
//  RUNNING  out  1  high while in RUN state
//  ERR      out  1  one-cycle pulse on a rejected LOAD
// BEHAVIOUR
//  Reset (RST=0 at edge): state IDLE; HORAT=MINT=SEGT=8'h00; ALARMA=RUNNING=ERR=0; prescaler=0.
//  All outputs registered. Change one cycle after the causing input or tick.
//  FSM states: IDLE, RUN, PAUSA, ALARM. Reset wins over every other input.
//   IDLE/PAUSA:
//    - LOAD valid -> digits loaded next cycle; next state PAUSA.
//    - START with count != 00:00:00 -> RUN, prescaler cleared to 0.
//    - START with count == 00:00:00 -> ignored.
//   RUN:
//    - STOP -> PAUSA; prescaler value discarded.
//    - Prescaler counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and the count decrements by 1 s.
//    - The decrement that reaches 00:00:00 also enters ALARM on the same edge.
//   ALARM:
//    - ALARMA=1. Digits hold at 00:00:00. Prescaler keeps running.
//    - ACK -> IDLE.
//    - ALARM_SECS ticks without ACK -> IDLE.
//  LOAD validity: every nibble <= 9, MIN/SEG tens <= 5, hours <= 8'h23.
//   - Invalid LOAD: digits unchanged; ERR=1 for exactly one cycle.
//   - LOAD in RUN or ALARM: ignored; no ERR.
//  Priority for simultaneous pulses: ACK > STOP > START > LOAD.
//   - STOP on a tick edge: no decrement; the pause takes effect.
//   - START and LOAD together in IDLE: START evaluated on the old count; LOAD ignored.
//  BCD decrement (digit-wise borrow, never binary arithmetic on the byte):
//   - sec units 0 -> 9, borrow to tens; sec tens 0 -> 5, borrow to min.
//   - Minutes behave the same way, borrowing to hours.
//   - Hour units 0 -> 9, borrow to tens; hour tens never decrement below 0 (zero detect precedes).
//  Reset mid-RUN or mid-ALARM: immediate return to reset values; loaded count is lost.
// TESTING
//  T1: RST=0 two cycles, all inputs toggling -> HORAT/MINT/SEGT=00, ALARMA=RUNNING=ERR=0.
//  T2: load 00:01:00, START -> first tick SEGT=8'h59/MINT=8'h00; 60th tick 00:00:00, ALARMA=1 same cycle.
//  T3: load 10:00:00, START, 1 tick -> HORAT=8'h09, MINT=8'h59, SEGT=8'h59.
//  T4: LOAD MIN_IN=8'h60 (also HORA_IN=8'h24, SEG_IN=8'h1A) -> ERR one-cycle pulse, digits unchanged.
//  T5: run 00:00:05, STOP on a tick edge -> stays 00:00:05, RUNNING=0; START -> next tick 00:00:04.
//  T6: alarm then ACK -> IDLE next cycle, ALARMA=0; alarm without ACK -> clears after 10 ticks;
//      RST=0 mid-RUN -> reset values.

Source files
------------

// File: rtl/temporizador_bcd.sv
// BCD countdown timer HH:MM:SS with alarm, feeding the VGA display stage.
// Ports: CLK, RST (sync, active-low), LOAD/START/STOP/ACK pulses, HORA_IN/MIN_IN/SEG_IN; HORAT/MINT/SEGT, ALARMA, RUNNING, ERR.
module temporizador_bcd #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int ALARM_SECS = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD,
  input  logic [7:0] HORA_IN,
  input  logic [7:0] MIN_IN,
  input  logic [7:0] SEG_IN,
  input  logic       START,
  input  logic       STOP,
  input  logic       ACK,
  output logic [7:0] HORAT,
  output logic [7:0] MINT,
  output logic [7:0] SEGT,
  output logic       ALARMA,
  output logic       RUNNING,
  output logic       ERR
);

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int AW = $clog2(ALARM_SECS + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSA,
    ALARM
  } state_t;

  state_t        state;
  logic [PW-1:0] pre;
  logic [AW-1:0] acnt;

  logic          tick;
  logic          nonzero;
  logic          load_ok;
  logic [23:0]   nxt;

  // Digit-wise borrow chain; tens of sec/min wrap to 5, all others to 9.
  function automatic logic [23:0] bcd_dec(input logic [23:0] t);
    logic [23:0] r;
    logic        b;
    r = t;
    b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = (i == 1 || i == 3) ? 4'd5 : 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick    = (pre == PW'(TICK_DIV - 1));
  assign nonzero = ({HORAT, MINT, SEGT} != 24'h0);
  assign nxt     = bcd_dec({HORAT, MINT, SEGT});

  assign load_ok = (HORA_IN[3:0] <= 4'd9) &&
                   (HORA_IN <= 8'h23) &&
                   (MIN_IN[3:0] <= 4'd9) &&
                   (MIN_IN[7:4] <= 4'd5) &&
                   (SEG_IN[3:0] <= 4'd9) &&
                   (SEG_IN[7:4] <= 4'd5);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= IDLE;
      pre     <= '0;
      acnt    <= '0;
      HORAT   <= 8'h00;
      MINT    <= 8'h00;
      SEGT    <= 8'h00;
      ALARMA  <= 1'b0;
      RUNNING <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      ERR <= 1'b0;
      unique case (state)
        IDLE, PAUSA: begin
          // START masks LOAD even when the zero count makes it a no-op.
          if (START) begin
            if (nonzero) begin
              state   <= RUN;
              RUNNING <= 1'b1;
              pre     <= '0;
            end
          end else if (LOAD) begin
            if (load_ok) begin
              HORAT <= HORA_IN;
              MINT  <= MIN_IN;
              SEGT  <= SEG_IN;
              state <= PAUSA;
            end else begin
              ERR <= 1'b1;
            end
          end
        end
        RUN: begin
          if (STOP) begin
            state   <= PAUSA;
            RUNNING <= 1'b0;
          end else if (tick) begin
            pre                  <= '0;
            {HORAT, MINT, SEGT}  <= nxt;
            if (nxt == 24'h0) begin
              state   <= ALARM;
              RUNNING <= 1'b0;
              ALARMA  <= 1'b1;
              acnt    <= '0;
            end
          end else begin
            pre <= pre + 1'b1;
          end
        end
        ALARM: begin
          if (ACK) begin
            state  <= IDLE;
            ALARMA <= 1'b0;
          end else if (tick) begin
            pre <= '0;
            if (acnt == AW'(ALARM_SECS - 1)) begin
              state  <= IDLE;
              ALARMA <= 1'b0;
            end else begin
              acnt <= acnt + 1'b1;
            end
          end else begin
            pre <= pre + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_temporizador_bcd.sv
// Testbench for temporizador_bcd: seconds-based reference model,
// expected outputs queued per cycle and checked by a separate monitor.
module tb_temporizador_bcd;

  localparam int TD = 4;
  localparam int AS = 10;

  logic       CLK = 1'b0;
  logic       RST, LOAD, START, STOP, ACK;
  logic [7:0] HORA_IN, MIN_IN, SEG_IN;
  logic [7:0] HORAT, MINT, SEGT;
  logic       ALARMA, RUNNING, ERR;

  temporizador_bcd #(.TICK_DIV(TD), .ALARM_SECS(AS)) dut (
    .CLK(CLK), .RST(RST), .LOAD(LOAD),
    .HORA_IN(HORA_IN), .MIN_IN(MIN_IN), .SEG_IN(SEG_IN),
    .START(START), .STOP(STOP), .ACK(ACK),
    .HORAT(HORAT), .MINT(MINT), .SEGT(SEGT),
    .ALARMA(ALARMA), .RUNNING(RUNNING), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef logic [26:0] exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: remaining time as plain seconds, mode 0 idle/1 run/2 pause/3 alarm.
  int m_secs, m_mode, m_cyc, m_ticks;
  bit m_err;

  function automatic int dec2(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic bit valid_t(input logic [7:0] h, m, s);
    bit ok;
    ok = (h[3:0] < 10) && (m[3:0] < 10) && (s[3:0] < 10);
    ok = ok && (h[7:4] < 10) && (m[7:4] < 6) && (s[7:4] < 6);
    return ok && (dec2(h) < 24);
  endfunction

  task automatic step(input bit rst, ld, input logic [7:0] h, m, s,
                      input bit st, sp, ak);
    RST = rst; LOAD = ld; HORA_IN = h; MIN_IN = m; SEG_IN = s;
    START = st; STOP = sp; ACK = ak;
    m_err = 0;
    if (!rst) begin
      m_secs = 0; m_mode = 0; m_cyc = 0; m_ticks = 0;
    end else if (m_mode == 0 || m_mode == 2) begin
      if (st) begin
        if (m_secs > 0) begin
          m_mode = 1; m_cyc = 0;
        end
      end else if (ld) begin
        if (valid_t(h, m, s)) begin
          m_secs = dec2(h) * 3600 + dec2(m) * 60 + dec2(s);
          m_mode = 2;
        end else begin
          m_err = 1;
        end
      end
    end else if (m_mode == 1) begin
      if (sp) begin
        m_mode = 2;
      end else begin
        m_cyc++;
        if (m_cyc == TD) begin
          m_cyc = 0;
          m_secs--;
          if (m_secs == 0) begin
            m_mode = 3; m_ticks = 0;
          end
        end
      end
    end else begin
      if (ak) begin
        m_mode = 0;
      end else begin
        m_cyc++;
        if (m_cyc == TD) begin
          m_cyc = 0;
          m_ticks++;
          if (m_ticks == AS) m_mode = 0;
        end
      end
    end
    q.push_back({to_bcd(m_secs / 3600), to_bcd((m_secs / 60) % 60),
                 to_bcd(m_secs % 60), m_mode == 3, m_mode == 1, m_err});
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
  endtask

  task automatic load(input logic [7:0] h, m, s);
    step(1, 1, h, m, s, 0, 0, 0);
  endtask

  task automatic start();
    step(1, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
  endtask

  task automatic run_to_alarm();
    for (int i = 0; i < 400 && m_mode != 3; i++) idle(1);
  endtask

  always begin
    @(posedge CLK);
    #1;
    cyc++;
    if (q.size() > 0) begin
      exp_t e, a;
      e = q.pop_front();
      a = {HORAT, MINT, SEGT, ALARMA, RUNNING, ERR};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cyc%0d outputs {H,M,S,AL,RUN,ERR}: got %h %h %h %b %b %b expected %h %h %h %b %b %b",
                 cyc, a[26:19], a[18:11], a[10:3], a[2], a[1], a[0],
                 e[26:19], e[18:11], e[10:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    logic [7:0] h, m, s;
    int r;
    // T1: reset with other inputs toggling
    step(0, 1, 8'h12, 8'h34, 8'h56, 1, 0, 0);
    step(0, 1, 8'h01, 8'h02, 8'h03, 1, 1, 1);
    idle(2);
    start();
    idle(1);
    // T2: 00:01:00 down to alarm, then auto-clear
    load(8'h00, 8'h01, 8'h00);
    start();
    run_to_alarm();
    idle(AS * TD + 3);
    // T3: hour borrow chain
    load(8'h10, 8'h00, 8'h00);
    start();
    idle(TD + 2);
    step(1, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    // T4: invalid loads keep the old digits
    load(8'h24, 8'h60, 8'h1A);
    idle(2);
    load(8'h23, 8'h59, 8'h5A);
    load(8'h23, 8'h59, 8'h59);
    idle(1);
    // T5: STOP on a tick edge, resume
    load(8'h00, 8'h00, 8'h05);
    start();
    for (int i = 0; i < 20 && m_cyc != TD - 1; i++) idle(1);
    step(1, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    idle(3);
    start();
    idle(TD + 1);
    // START and LOAD together: load is dropped
    step(1, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    step(1, 1, 8'h01, 8'h00, 8'h00, 1, 0, 0);
    idle(2);
    // T6: alarm with ACK, then reset mid-run
    step(1, 1, 8'h00, 8'h00, 8'h02, 0, 1, 0);
    start();
    run_to_alarm();
    idle(3);
    step(1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);
    idle(2);
    load(8'h01, 8'h00, 8'h00);
    start();
    idle(7);
    step(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    idle(2);
    // Randomised phase
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      h = 8'h00;
      m = to_bcd($urandom_range(0, 1));
      s = to_bcd($urandom_range(0, 59));
      if ($urandom_range(0, 4) == 0) begin
        h = 8'($urandom); m = 8'($urandom); s = 8'($urandom);
      end
      if (r < 6)       step(1, 1, h, m, s, 0, 0, 0);
      else if (r < 12) step(1, 0, h, m, s, 1, 0, 0);
      else if (r < 15) step(1, 0, h, m, s, 0, 1, 0);
      else if (r < 18) step(1, 0, h, m, s, 0, 0, 1);
      else if (r < 20) step(1, 1, h, m, s, 1, 0, 0);
      else if (r < 21) step(0, 0, h, m, s, 0, 0, 0);
      else             idle(1);
    end
    idle(2);
    repeat (3) @(posedge CLK);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
